// File: rtl/alu_pkg.sv
// Shared opcode/select encodings for the ALU issue path and the opcode decoder.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL1 = 4'h5;
  localparam logic [3:0] OP_SHR1 = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;

  localparam logic [2:0] SEL_NOP  = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_XOR  = 3'b100;
  localparam logic [2:0] SEL_SHL1 = 3'b101;
  localparam logic [2:0] SEL_SHR1 = 3'b110;
  localparam logic [2:0] SEL_XNOR = 3'b111;

  // Returns {illegal, sel}; undefined opcodes map to the NOP select so the ALU yields 0.
  function automatic logic [3:0] op2sel(input logic [3:0] op);
    case (op)
      OP_NOP:  op2sel = {1'b0, SEL_NOP};
      OP_ADD:  op2sel = {1'b0, SEL_ADD};
      OP_AND:  op2sel = {1'b0, SEL_AND};
      OP_OR:   op2sel = {1'b0, SEL_OR};
      OP_XOR:  op2sel = {1'b0, SEL_XOR};
      OP_SHL1: op2sel = {1'b0, SEL_SHL1};
      OP_SHR1: op2sel = {1'b0, SEL_SHR1};
      OP_XNOR: op2sel = {1'b0, SEL_XNOR};
      default: op2sel = {1'b1, SEL_NOP};
    endcase
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer: a main entry driving the outputs plus one skid entry.
// Upstream ready is simply "skid empty", so it comes straight from a flop.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_vld;
  logic         r_skid_vld;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_acc;
  logic         w_iss;

  assign w_acc   = i_valid & ~r_skid_vld;
  assign w_iss   = r_main_vld & i_ready;
  assign o_ready = ~r_skid_vld;
  assign o_valid = r_main_vld;
  assign o_data  = r_main;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (!r_main_vld || w_iss) begin
      // Main is free this cycle: refill from skid first to keep FIFO order.
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_acc) begin
        r_main     <= i_data;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid     <= i_data;
      r_skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes opcodes, buffers ops in a 2-entry skid, drives the combinational ALU.
// Define ALU_ISSUE_FWD_EN to let an op take the previous ALU result as operand A.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_fwd_a,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             illegal_op
);

`ifdef ALU_ISSUE_FWD_EN
  localparam int PW = 2*WIDTH + 4;
`else
  localparam int PW = 2*WIDTH + 3;
`endif

  logic [3:0]    w_dec;
  logic          w_acc;
  logic [PW-1:0] w_in_pl;
  logic [PW-1:0] w_main;
  logic          r_illegal;

  assign w_dec = op2sel(in_op);
  assign w_acc = in_valid & in_ready;

`ifdef ALU_ISSUE_FWD_EN
  assign w_in_pl = {in_fwd_a, w_dec[2:0], in_b, in_a};
`else
  assign w_in_pl = {w_dec[2:0], in_b, in_a};
`endif

  alu_skid_buf #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_pl),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_main)
  );

  assign data_b = w_main[2*WIDTH-1:WIDTH];
  assign select = w_main[2*WIDTH+2:2*WIDTH];

`ifdef ALU_ISSUE_FWD_EN
  logic [WIDTH-1:0] r_last_y;
  logic             w_unused;

  // In-order issue means the producer has already issued by the time a consumer reaches main.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_last_y <= '0;
    else if (out_valid && out_ready) r_last_y <= alu_y;
  end

  assign data_a   = w_main[PW-1] ? r_last_y : w_main[WIDTH-1:0];
  assign w_unused = &{1'b0, alu_zero};
`else
  logic w_unused;

  assign data_a   = w_main[WIDTH-1:0];
  assign w_unused = &{1'b0, in_fwd_a, alu_y, alu_zero};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_illegal <= 1'b0;
    else if (w_acc && w_dec[3]) r_illegal <= 1'b1;
  end

  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_issue_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_fwd_a;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [2:0]   select;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_y;
  logic         alu_zero;
  logic         illegal_op;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_fwd_a(in_fwd_a),
    .data_a(data_a), .data_b(data_b), .select(select),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_y(alu_y), .alu_zero(alu_zero), .illegal_op(illegal_op)
  );

  function automatic logic [W-1:0] alu_f(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      3'd1:    alu_f = a + b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = a << 1;
      3'd6:    alu_f = a >> 1;
      3'd7:    alu_f = ~(a ^ b);
      default: alu_f = '0;
    endcase
  endfunction

  // Stand-in for the downstream combinational ALU.
  always_comb begin
    alu_y    = alu_f(select, data_a, data_b);
    alu_zero = (alu_y == '0);
  end

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fwd;
  } mop_t;

  mop_t         q[$];
  logic         m_ill;
  logic [W-1:0] m_last_y;
  int           n_chk  = 0;
  int           n_pass = 0;
  int           dut_iss;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] dsel(input logic [3:0] op);
    dsel = (op < 4'd8) ? op[2:0] : 3'd0;
  endfunction

  function automatic logic [W-1:0] eff_a(input mop_t m);
`ifdef ALU_ISSUE_FWD_EN
    eff_a = m.fwd ? m_last_y : m.a;
`else
    eff_a = m.a;
`endif
  endfunction

  task automatic check_outs();
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("in_ready", W'(in_ready), W'(q.size() < 2));
    chk("illegal_op", W'(illegal_op), W'(m_ill));
    if (q.size() > 0) begin
      chk("data_a", data_a, eff_a(q[0]));
      chk("data_b", data_b, q[0].b);
      chk("select", W'(select), W'(dsel(q[0].op)));
      chk("alu_y", alu_y, alu_f(dsel(q[0].op), eff_a(q[0]), q[0].b));
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs, steps the model, checks at the next falling edge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic fwd, input logic ordy);
    mop_t m;
    logic acc, iss;
    in_valid = v; in_op = op; in_a = a; in_b = b; in_fwd_a = fwd; out_ready = ordy;
    if (out_valid && ordy) dut_iss++;
    acc = v && (q.size() < 2);
    iss = ordy && (q.size() > 0);
    if (iss) begin
      m_last_y = alu_f(dsel(q[0].op), eff_a(q[0]), q[0].b);
      void'(q.pop_front());
    end
    if (acc) begin
      m.op = op; m.a = a; m.b = b; m.fwd = fwd;
      q.push_back(m);
      if (op >= 4'd8) m_ill = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_illegal"}, W'(illegal_op), '0);
    chk({tag, "_data_a"}, data_a, '0);
    chk({tag, "_select"}, W'(select), '0);
    q.delete(); m_ill = 1'b0; m_last_y = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_fwd_a = 1'b0;
    out_ready = 1'b0; m_ill = 1'b0; m_last_y = '0; dut_iss = 0;
    @(negedge clk);
    do_reset("rst0");
    chk("rst0_data_b", data_b, '0);

    // Single ADD, 1-cycle latency
    cycle(1'b1, 4'h1, 32'd5, 32'd7, 1'b0, 1'b1);
    chk("add_sel", W'(select), W'(3'b001));
    chk("add_a", data_a, 32'd5);
    chk("add_b", data_b, 32'd7);
    chk("add_y", alu_y, 32'd12);
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);

    // Stall: 3 pushes, 2 accepted; then drain in order
    cycle(1'b1, 4'h1, 32'd10, 32'd1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 32'd11, 32'd2, 1'b0, 1'b0);
    chk("full_in_ready", W'(in_ready), '0);
    cycle(1'b1, 4'h3, 32'd12, 32'd3, 1'b0, 1'b0);
    chk("full_hold_sel", W'(select), W'(3'b001));
    chk("full_hold_a", data_a, 32'd10);
    cycle(1'b1, 4'h3, 32'd12, 32'd3, 1'b0, 1'b1);
    chk("order_2nd", W'(select), W'(3'b010));
    cycle(1'b1, 4'h3, 32'd12, 32'd3, 1'b0, 1'b1);
    chk("order_3rd", W'(select), W'(3'b011));
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    chk("drained", W'(out_valid), '0);

    // Back-to-back accept+issue
    dut_iss = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'h1, W'(i), W'(100), 1'b0, 1'b1);
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    chk("b2b_issues", W'(dut_iss), W'(10));

    // Illegal opcode
    cycle(1'b1, 4'hA, 32'h55, 32'h66, 1'b0, 1'b1);
    chk("ill_sel", W'(select), '0);
    chk("ill_valid", W'(out_valid), W'(1));
    chk("ill_flag", W'(illegal_op), W'(1));
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 4'h1, 32'd1, 32'd1, 1'b0, 1'b1);
    chk("ill_sticky", W'(illegal_op), W'(1));
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);

    // Forwarding: ADD 3+4 then XOR with fwd_a
    cycle(1'b1, 4'h1, 32'd3, 32'd4, 1'b0, 1'b1);
    cycle(1'b1, 4'h4, 32'd9, 32'd1, 1'b1, 1'b1);
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_a", data_a, 32'd7);
    chk("fwd_y", alu_y, 32'd6);
`else
    chk("nofwd_a", data_a, 32'd9);
    chk("nofwd_y", alu_y, 32'd8);
`endif
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'b1 & ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), W'($urandom),
            W'($urandom), 1'($urandom_range(0, 1)), 1'b1 & ($urandom_range(0, 2) != 0));

    // Reset with both entries full
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 4'hF, 32'd1, 32'd2, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("pre_rst_full", W'(in_ready), '0);
    do_reset("rst_mid");
    cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    chk("post_rst_valid", W'(out_valid), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
